// File: rtl/hkspi_responder_if.sv
// Housekeeping SPI responder bus: SPI pad signals plus the single-byte
// register-file strobe interface. The responder uses the slave modport,
// the host/register-file side uses the master modport.
interface hkspi_responder_if;
  logic       sck;
  logic       csb;
  logic       sdi;
  logic       sdo;
  logic       sdo_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport master (
    output sck, csb, sdi, reg_rdata,
    input  sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport slave (
    input  sck, csb, sdi, reg_rdata,
    output sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/hkspi_responder.sv
// Housekeeping SPI target (mode 0, MSB first) running entirely in the core
// clock domain. Decodes command/address/data bytes into single-byte register
// read and write strobes; read data is shifted out on sdo.
// Optional macro HKSPI_NBYTE_EN: a nonzero command bits[5:3] limits the
// transfer to that many data bytes, after which the rest is ignored.
module hkspi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  hkspi_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, IGNORE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync;
  logic                   sck_s, csb_s, sdi_s;
  logic                   sck_d, csb_d, csb_armed;
  logic                   sck_rise, sck_fall, csb_fall;
  logic                   shifting, byte_done, last_byte;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shreg;
  logic [7:0]             rx_byte, tx_shreg;
  logic [1:0]             mode;
  logic                   re_pend, incr_pend;
`ifdef HKSPI_NBYTE_EN
  logic [2:0]             byte_limit, byte_cnt;
`endif

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  // csb_armed only rises once csb has been seen high after reset, so a chip
  // select still held low across a reset can never start a transaction.
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csb_fall = csb_armed & csb_d & ~csb_s;
  assign bus.busy = csb_armed & ~csb_s;

  assign shifting  = !csb_s && (state == COMMAND || state == ADDRESS || state == DATA);
  assign byte_done = shifting && sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shreg, sdi_s};

`ifdef HKSPI_NBYTE_EN
  assign last_byte = (byte_limit != 3'd0) && (byte_cnt + 3'd1 == byte_limit);
`else
  assign last_byte = 1'b0;
`endif

  // Pad synchronizers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sck_sync  <= '0;
      csb_sync  <= '0;
      sdi_sync  <= '0;
      sck_d     <= 1'b0;
      csb_d     <= 1'b0;
      csb_armed <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], bus.csb};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      sck_d     <= sck_s;
      csb_d     <= csb_s;
      csb_armed <= csb_armed | csb_s;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode; a deasserted chip select wins over any sck edge
  always_comb begin
    state_next = state;
    if (csb_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (csb_fall)  state_next = COMMAND;
        COMMAND: if (byte_done) state_next = (rx_byte[7:6] == 2'b00) ? IGNORE : ADDRESS;
        ADDRESS: if (byte_done) state_next = DATA;
        DATA:    if (byte_done && last_byte) state_next = IGNORE;
        default: state_next = state;
      endcase
    end
  end

  // Byte assembly, register strobes, address stepping and read-data shifting
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bit_cnt       <= 3'd0;
      rx_shreg      <= '0;
      tx_shreg      <= '0;
      mode          <= 2'b00;
      re_pend       <= 1'b0;
      incr_pend     <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
      bus.sdo       <= 1'b0;
      bus.sdo_oe    <= 1'b0;
`ifdef HKSPI_NBYTE_EN
      byte_limit    <= 3'd0;
      byte_cnt      <= 3'd0;
`endif
    end else begin
      bus.reg_we <= 1'b0;
      bus.reg_re <= re_pend;
      re_pend    <= 1'b0;
      incr_pend  <= 1'b0;

      if (incr_pend) bus.reg_addr <= bus.reg_addr + 8'd1;

      if (bus.reg_re) begin
        tx_shreg <= bus.reg_rdata;
      end else if (state == DATA && !csb_s && sck_fall && mode[0]) begin
        bus.sdo  <= tx_shreg[7];
        tx_shreg <= {tx_shreg[6:0], 1'b0};
      end

      if (csb_s) begin
        bit_cnt    <= 3'd0;
        bus.sdo_oe <= 1'b0;
      end else if (shifting && sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shreg <= rx_byte[6:0];
        if (byte_done) begin
          case (state)
            COMMAND: begin
              mode <= rx_byte[7:6];
`ifdef HKSPI_NBYTE_EN
              byte_limit <= rx_byte[5:3];
`endif
            end
            ADDRESS: begin
              bus.reg_addr <= rx_byte;
              re_pend      <= mode[0];
              bus.sdo_oe   <= mode[0];
`ifdef HKSPI_NBYTE_EN
              byte_cnt     <= 3'd0;
`endif
            end
            DATA: begin
              incr_pend <= 1'b1;
              re_pend   <= mode[0] && !last_byte;
              if (mode[1]) begin
                bus.reg_we    <= 1'b1;
                bus.reg_wdata <= rx_byte;
              end
`ifdef HKSPI_NBYTE_EN
              byte_cnt <= byte_cnt + 3'd1;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
// Self-checking bench for hkspi_responder: an SPI host drives directed and
// random transactions, a reference model turns each transaction into the
// expected register strobes and read bytes, and independent monitors pop and
// compare them as the DUT produces them. The register file returns addr^0xA5.
module tb_hkspi_responder;
  localparam int HALF = 8;
  typedef logic [7:0] bytes8_t [8];

  logic        clock = 1'b0;
  logic        resetn;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];
  logic [8:0]  exp_rd[$];
  int          rd_bits = 0;
  logic [7:0]  rd_sh = '0;
  bytes8_t     d;

  hkspi_responder_if bus();

  hkspi_responder #(.SYNC_STAGES(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.reg_rdata = bus.reg_addr ^ 8'hA5;

  // Core clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got unexpected 0x%0h, expected none", name, act);
  endtask

  // Register-bus monitor: each strobe is matched against the scoreboard
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.reg_we) begin
        if (exp_we.size() == 0) reportUnexpected("reg_we", {16'h0, bus.reg_addr, bus.reg_wdata});
        else checkOutput("reg_we addr/data", {16'h0, bus.reg_addr, bus.reg_wdata}, {16'h0, exp_we.pop_front()});
      end
      if (bus.reg_re) begin
        if (exp_re.size() == 0) reportUnexpected("reg_re", {24'h0, bus.reg_addr});
        else checkOutput("reg_re addr", {24'h0, bus.reg_addr}, {24'h0, exp_re.pop_front()});
      end
    end
  end

  // Host-side read monitor: collects sdo on sck rises during a read data phase
  always @(posedge bus.sck or posedge bus.csb) begin : rd_mon
    logic [8:0] e;
    if (bus.csb) begin
      rd_bits = 0;
    end else if (bus.sdo_oe) begin
      rd_sh = {rd_sh[6:0], bus.sdo};
      rd_bits++;
      if (rd_bits == 8) begin
        rd_bits = 0;
        if (exp_rd.size() == 0) begin
          reportUnexpected("sdo byte", {24'h0, rd_sh});
        end else begin
          e = exp_rd.pop_front();
          if (e[8]) checkOutput("sdo byte", {24'h0, rd_sh}, {24'h0, e[7:0]});
        end
      end
    end
  end

  task automatic spiByte(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.sdi = b[7-i];
      repeat (HALF) @(negedge clock);
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clock);
      bus.sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr,
                               input bytes8_t data, input int ndata, input int partial);
    logic [2:0] limit;
    logic [7:0] a;
    logic       rd;
    logic       wr;
    rd = cmd[6];
    wr = cmd[7];
`ifdef HKSPI_NBYTE_EN
    limit = cmd[5:3];
`else
    limit = 3'd0;
`endif
    if (rd || wr) begin
      if (rd) exp_re.push_back(addr);
      for (int k = 0; k < ndata; k++) begin
        a = addr + 8'(k);
        if (limit == 3'd0 || k < int'(limit)) begin
          if (wr) exp_we.push_back({a, data[k]});
          if (rd) begin
            exp_rd.push_back({1'b1, a ^ 8'hA5});
            if (limit == 3'd0 || k + 1 < int'(limit)) exp_re.push_back(a + 8'd1);
          end
        end else if (rd) begin
          exp_rd.push_back(9'h000);
        end
      end
    end

    bus.csb = 1'b0;
    spiByte(cmd, 8);
    spiByte(addr, 8);
    for (int k = 0; k < ndata; k++) spiByte(data[k], 8);
    if (partial > 0) spiByte(8'($urandom), partial);
    repeat (HALF) @(negedge clock);
    checkOutput("busy active", 32'(bus.busy), 32'd1);
    checkOutput("sdo_oe active", 32'(bus.sdo_oe), 32'(rd));
    bus.csb = 1'b1;
    repeat (3 * HALF) @(negedge clock);
    checkOutput("busy idle", 32'(bus.busy), 32'd0);
    checkOutput("sdo_oe idle", 32'(bus.sdo_oe), 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset reg_we", 32'(bus.reg_we), 32'd0);
    checkOutput("reset reg_re", 32'(bus.reg_re), 32'd0);
    checkOutput("reset sdo", 32'(bus.sdo), 32'd0);
    checkOutput("reset sdo_oe", 32'(bus.sdo_oe), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset reg_addr", 32'(bus.reg_addr), 32'd0);
    checkOutput("reset reg_wdata", 32'(bus.reg_wdata), 32'd0);
  endtask

  // Main sequence: reset, directed transactions, mid-transfer reset, random traffic
  initial begin
    bus.sck = 1'b0;
    bus.csb = 1'b1;
    bus.sdi = 1'b0;
    resetn  = 1'b0;
    d = '{default: 8'h00};
    repeat (4) @(negedge clock);
    checkResetOutputs();
    resetn = 1'b1;
    repeat (6) @(negedge clock);

    $display("[TB] directed transactions");
    d[0] = 8'h66;                applyStimulus(8'h80, 8'h13, d, 1, 0);
    d[0] = 8'hAA; d[1] = 8'h55;  applyStimulus(8'h80, 8'h12, d, 2, 0);
    d[0] = 8'h00; d[1] = 8'h00;  applyStimulus(8'h40, 8'h05, d, 2, 0);
    d[0] = 8'h01; d[1] = 8'h02;  applyStimulus(8'h80, 8'hFF, d, 2, 0);
    applyStimulus(8'h80, 8'h20, d, 0, 5);
    d[0] = 8'h3C;                applyStimulus(8'h80, 8'h20, d, 1, 0);
    d[0] = 8'h11; d[1] = 8'h22;  applyStimulus(8'h88, 8'h30, d, 2, 0);
    d[0] = 8'h5A; d[1] = 8'hC3;  applyStimulus(8'hC0, 8'h7E, d, 2, 0);
    applyStimulus(8'h00, 8'h44, d, 2, 0);

    $display("[TB] reset during a transfer");
    bus.csb = 1'b0;
    spiByte(8'h80, 8);
    spiByte(8'h44, 8);
    spiByte(8'hF0, 3);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkResetOutputs();
    resetn = 1'b1;
    spiByte(8'h99, 8);
    spiByte(8'h5A, 8);
    repeat (HALF) @(negedge clock);
    checkOutput("busy after reset", 32'(bus.busy), 32'd0);
    bus.csb = 1'b1;
    repeat (3 * HALF) @(negedge clock);
    d[0] = 8'h77;                applyStimulus(8'h80, 8'h45, d, 1, 0);

    $display("[TB] random transactions");
    for (int t = 0; t < 16; t++) begin
      logic [7:0] cmd;
      logic [7:0] addr;
      int         n;
      int         p;
      cmd  = 8'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      n    = int'($urandom_range(0, 4));
      p    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      applyStimulus(cmd, addr, d, n, p);
    end

    repeat (10) @(negedge clock);
    checkOutput("reg_we left pending", 32'(exp_we.size()), 32'd0);
    checkOutput("reg_re left pending", 32'(exp_re.size()), 32'd0);
    checkOutput("sdo bytes left pending", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
